// File: rtl/loader_pkg.sv
// Shared types and byte constants for the instruction RAM boot loader.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_RESP
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_HALT = 8'h03;

    localparam logic [7:0] ST_OK  = 8'h4F;
    localparam logic [7:0] ST_ERR = 8'h45;

endpackage

// File: rtl/word_packer.sv
// Assembles little-endian bytes into RAM words and issues one write strobe per word.
module word_packer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            clear_i,
    input  logic            byte_valid_i,
    input  logic [7:0]      byte_i,
    input  logic            last_i,
    input  logic [XLEN-1:0] addr_i,
    output logic            full_c,
    output logic            wr_en_o,
    output logic [XLEN-1:0] wr_addr_o,
    output logic [XLEN-1:0] wr_data_o,
    output logic [3:0]      wr_byte_en_o
);

    logic [1:0]      lane_q;
    logic [XLEN-1:0] data_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] data_nx;
    logic [3:0]      be_nx;
    logic            flush;

    logic            wr_en_q;
    logic [XLEN-1:0] wr_addr_q;
    logic [XLEN-1:0] wr_data_q;
    logic [3:0]      wr_be_q;

    assign full_c = (lane_q == 2'd3);
    assign flush  = byte_valid_i && (full_c || last_i);

    // Merge the incoming byte into its lane
    always_comb begin
        data_nx = data_q;
        be_nx   = be_q;
        data_nx[8*lane_q +: 8] = byte_i;
        be_nx[lane_q]          = 1'b1;
    end

    // Lane accumulation and registered write port
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lane_q    <= '0;
            data_q    <= '0;
            be_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_be_q   <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (clear_i) begin
                lane_q <= '0;
                data_q <= '0;
                be_q   <= '0;
            end else if (flush) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= addr_i;
                wr_data_q <= data_nx;
                wr_be_q   <= be_nx;
                lane_q    <= '0;
                data_q    <= '0;
                be_q      <= '0;
            end else if (byte_valid_i) begin
                lane_q <= lane_q + 2'd1;
                data_q <= data_nx;
                be_q   <= be_nx;
            end
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign wr_byte_en_o = wr_be_q;

endmodule

// File: rtl/iram_loader.sv
// Boot-time loader: decodes UART command frames, fills instruction RAM, controls core reset.
module iram_loader
    import loader_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned IRAM_AW  = 14,
    parameter int unsigned TIMEOUT  = 1000000,
    parameter int unsigned BOOT_RUN = 0
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [7:0]      rx_data_i,
    input  logic            rx_valid_i,
    output logic [7:0]      tx_data_o,
    output logic            tx_valid_o,
    input  logic            tx_ready_i,
    output logic            iram_wr_en_o,
    output logic [XLEN-1:0] iram_wr_addr_o,
    output logic [XLEN-1:0] iram_wr_data_o,
    output logic [3:0]      iram_wr_byte_en_o,
    output logic            cpu_rst_n_o,
    output logic            busy_o
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned EW    = XLEN + 1;
    localparam logic [EW-1:0] IRAM_BYTES = EW'(1) << IRAM_AW;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   len_q, len_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              busy_q, busy_d;

    logic              pk_valid;
    logic              pk_last;
    logic              pk_clear;
    logic              pk_full_c;
    logic              tmo_hit;
    logic [XLEN-1:0]   len_full;

    assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT - 1));
    assign len_full = {rx_data_i, len_q[XLEN-1:8]};

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            tmo_q       <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            cpu_rst_n_q <= (BOOT_RUN != 0);
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            tmo_q       <= tmo_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
        end
    end

    // Frame decode, length checks, timeout and response sequencing
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        len_d       = len_q;
        rem_d       = rem_q;
        tmo_d       = tmo_q;
        tx_data_d   = tx_data_q;
        cpu_rst_n_d = cpu_rst_n_q;
        pk_valid    = 1'b0;
        pk_last     = 1'b0;
        pk_clear    = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                cnt_d = '0;
                if (rx_valid_i) begin
                    case (rx_data_i)
                        CMD_LOAD: begin
                            cpu_rst_n_d = 1'b0;
                            pk_clear    = 1'b1;
                            state_d     = S_ADDR;
                        end
                        CMD_RUN: begin
                            cpu_rst_n_d = 1'b1;
                            tx_data_d   = ST_OK;
                            state_d     = S_RESP;
                        end
                        CMD_HALT: begin
                            cpu_rst_n_d = 1'b0;
                            tx_data_d   = ST_OK;
                            state_d     = S_RESP;
                        end
                        default: begin
                            tx_data_d = ST_ERR;
                            state_d   = S_RESP;
                        end
                    endcase
                end
            end

            S_ADDR: begin
                if (rx_valid_i) begin
                    addr_d = {rx_data_i, addr_q[XLEN-1:8]};
                    cnt_d  = cnt_q + 2'd1;
                    tmo_d  = '0;
                    if (cnt_q == 2'd3) begin
                        state_d = S_LEN;
                    end
                end else if (tmo_hit) begin
                    tx_data_d = ST_ERR;
                    state_d   = S_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_LEN: begin
                if (rx_valid_i) begin
                    len_d = len_full;
                    cnt_d = cnt_q + 2'd1;
                    tmo_d = '0;
                    if (cnt_q == 2'd3) begin
                        rem_d = len_full;
                        if (addr_q[1:0] != 2'b00) begin
                            tx_data_d = ST_ERR;
                            state_d   = S_RESP;
                        end else if ((EW'(addr_q) + EW'(len_full)) > IRAM_BYTES) begin
                            tx_data_d = ST_ERR;
                            state_d   = S_RESP;
                        end else if (len_full == '0) begin
                            tx_data_d = ST_OK;
                            state_d   = S_RESP;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end else if (tmo_hit) begin
                    tx_data_d = ST_ERR;
                    state_d   = S_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_DATA: begin
                // rem_q reaches zero on the cycle the final strobe is on the port
                if (rem_q == '0) begin
                    tx_data_d = ST_OK;
                    state_d   = S_RESP;
                end else if (rx_valid_i) begin
                    pk_valid = 1'b1;
                    pk_last  = (rem_q == XLEN'(1));
                    rem_d    = rem_q - XLEN'(1);
                    tmo_d    = '0;
                    if (pk_full_c || pk_last) begin
                        addr_d = addr_q + XLEN'(4);
                    end
                end else if (tmo_hit) begin
                    pk_clear  = 1'b1;
                    tx_data_d = ST_ERR;
                    state_d   = S_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_RESP: begin
                if (tx_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        tx_valid_d = (state_d == S_RESP);
        busy_d     = (state_d != S_IDLE);
    end

    word_packer #(
        .XLEN (XLEN)
    ) u_packer (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .clear_i      (pk_clear),
        .byte_valid_i (pk_valid),
        .byte_i       (rx_data_i),
        .last_i       (pk_last),
        .addr_i       (addr_q),
        .full_c       (pk_full_c),
        .wr_en_o      (iram_wr_en_o),
        .wr_addr_o    (iram_wr_addr_o),
        .wr_data_o    (iram_wr_data_o),
        .wr_byte_en_o (iram_wr_byte_en_o)
    );

    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign cpu_rst_n_o = cpu_rst_n_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_iram_loader.sv
// Scoreboard bench for iram_loader: expected writes and status bytes queued at stimulus time.
module tb_iram_loader;

    localparam int unsigned TMO = 64;
    localparam logic [7:0] OK  = 8'h4F;
    localparam logic [7:0] ERR = 8'h45;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        cpu_rst_n;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [67:0] wr_q[$];
    logic [7:0]  tx_q[$];

    iram_loader #(
        .XLEN     (32),
        .IRAM_AW  (14),
        .TIMEOUT  (TMO),
        .BOOT_RUN (0)
    ) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .rx_data_i         (rx_data),
        .rx_valid_i        (rx_valid),
        .tx_data_o         (tx_data),
        .tx_valid_o        (tx_valid),
        .tx_ready_i        (tx_ready),
        .iram_wr_en_o      (wr_en),
        .iram_wr_addr_o    (wr_addr),
        .iram_wr_data_o    (wr_data),
        .iram_wr_byte_en_o (wr_be),
        .cpu_rst_n_o       (cpu_rst_n),
        .busy_o            (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_q.push_back({a, d, be});
    endtask

    // Scoreboard: compare RAM writes and TX handshakes against queued expectations
    always @(negedge clk) begin
        logic [67:0] e;
        logic [7:0]  t;
        if (rst_n) begin
            if (wr_en) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected", 64'(wr_en), 64'(0));
                end else begin
                    e = wr_q.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(e[67:36]));
                    check("wr_data", 64'(wr_data), 64'(e[35:4]));
                    check("wr_be",   64'(wr_be),   64'(e[3:0]));
                end
            end
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    check("tx_unexpected", 64'(tx_valid), 64'(0));
                end else begin
                    t = tx_q.pop_front();
                    check("tx_data", 64'(tx_data), 64'(t));
                end
            end
        end
    end

    // Entered and left at posedge+1
    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            send(w[8*i +: 8]);
        end
    endtask

    task automatic load_hdr(input logic [31:0] a, input logic [31:0] len);
        send(8'h01);
        send_word(a);
        send_word(len);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((tx_q.size() != 0 || busy) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_idle"}, 64'(busy), 64'(0));
        check({tag, "_txq"}, 64'(tx_q.size()), 64'(0));
        check({tag, "_wrq"}, 64'(wr_q.size()), 64'(0));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tx_valid"},  64'(tx_valid),  64'(0));
        check({tag, "_tx_data"},   64'(tx_data),   64'(0));
        check({tag, "_wr_en"},     64'(wr_en),     64'(0));
        check({tag, "_wr_addr"},   64'(wr_addr),   64'(0));
        check({tag, "_wr_data"},   64'(wr_data),   64'(0));
        check({tag, "_wr_be"},     64'(wr_be),     64'(0));
        check({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'(0));
        check({tag, "_busy"},      64'(busy),      64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        logic ever_released;
        logic unstable;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_vals("reset");

        ever_released = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (cpu_rst_n) ever_released = 1'b1;
        end
        check("cpu_held_after_reset", 64'(ever_released), 64'(0));

        // Two full words at 0x100
        expect_wr(32'h0000_0100, 32'h0000_0013, 4'hF);
        expect_wr(32'h0000_0104, 32'h0000_006F, 4'hF);
        tx_q.push_back(OK);
        load_hdr(32'h0000_0100, 32'd8);
        check("load_cpu_rst", 64'(cpu_rst_n), 64'(0));
        send_word(32'h0000_0013);
        send_word(32'h0000_006F);
        wait_idle("load8");

        // Partial final word
        expect_wr(32'h0000_0000, 32'h4433_2211, 4'hF);
        expect_wr(32'h0000_0004, 32'h0000_6655, 4'b0011);
        tx_q.push_back(OK);
        load_hdr(32'h0000_0000, 32'd6);
        send_word(32'h4433_2211);
        send(8'h55);
        send(8'h66);
        wait_idle("load6");

        // Misaligned start
        tx_q.push_back(ERR);
        load_hdr(32'h0000_0002, 32'd4);
        wait_idle("misaligned");

        // Overruns end of RAM by 4 bytes
        tx_q.push_back(ERR);
        load_hdr(32'h0000_3FFC, 32'd8);
        wait_idle("overrun");

        // Exactly fills the last word
        expect_wr(32'h0000_3FFC, 32'hDEAD_BEEF, 4'hF);
        tx_q.push_back(OK);
        load_hdr(32'h0000_3FFC, 32'd4);
        send_word(32'hDEAD_BEEF);
        wait_idle("last_word");

        // Zero length
        tx_q.push_back(OK);
        load_hdr(32'h0000_0010, 32'd0);
        wait_idle("len0");

        // Stall mid-word until timeout
        tx_q.push_back(ERR);
        load_hdr(32'h0000_0020, 32'd8);
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        wait_idle("timeout");

        // RUN releases core next cycle
        tx_q.push_back(OK);
        send(8'h02);
        check("run_cpu_rst", 64'(cpu_rst_n), 64'(1));
        wait_idle("run");

        tx_q.push_back(ERR);
        send(8'h77);
        check("bad_cmd_cpu_rst", 64'(cpu_rst_n), 64'(1));
        wait_idle("bad_cmd");

        tx_q.push_back(OK);
        send(8'h03);
        check("halt_cpu_rst", 64'(cpu_rst_n), 64'(0));
        wait_idle("halt");

        // Back-pressure: status held stable, rx during RESP ignored
        tx_ready = 1'b0;
        tx_q.push_back(ERR);
        send(8'h77);
        check("stall_tx_valid", 64'(tx_valid), 64'(1));
        unstable = 1'b0;
        send(8'h02);
        repeat (20) begin
            if (!tx_valid || tx_data !== ERR) unstable = 1'b1;
            @(posedge clk);
            #1;
        end
        check("stall_stable", 64'(unstable), 64'(0));
        check("stall_rx_dropped", 64'(cpu_rst_n), 64'(0));
        tx_ready = 1'b1;
        wait_idle("stall");

        // Reset in the middle of the second word
        expect_wr(32'h0000_0040, 32'h0403_0201, 4'hF);
        load_hdr(32'h0000_0040, 32'd8);
        send_word(32'h0403_0201);
        send(8'h05);
        send(8'h06);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals("midreset");
        rst_n = 1'b1;
        repeat (TMO + 10) begin
            @(posedge clk);
            #1;
        end
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_wrq", 64'(wr_q.size()), 64'(0));
        check("midreset_txq", 64'(tx_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
